// File: rtl/doa_pkg.sv
// doa_pkg: shared types and constants for the DOA frame reader.
// Bank states, packing-order field offsets and drop counter width.
package doa_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_st_t;

  localparam int DROP_CNT_WIDTH = 16;
  localparam int NUM_FIELDS     = 5;

  // Field slot indices inside m_data, in units of DIN_WIDTH.
  localparam int FLD_LAMB1    = 4;
  localparam int FLD_LAMB2    = 3;
  localparam int FLD_EIGEN1_Y = 2;
  localparam int FLD_EIGEN2_Y = 1;
  localparam int FLD_EIGEN_X  = 0;

endpackage

// File: rtl/doa_pingpong_ram.sv
// doa_pingpong_ram: simple dual-port RAM holding both frame banks.
// Bank select is the address MSB; read data is registered (1 cycle).
module doa_pingpong_ram #(
  parameter int DW = 80,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/doa_frame_reader.sv
// doa_frame_reader: ping-pong frame buffer for eigen outputs.
// Define DOA_ERR_FLAG_EN to carry din_error through to m_data/err_sticky.
module doa_frame_reader
  import doa_pkg::*;
#(
  parameter int DIN_WIDTH  = 16,
  parameter int VECTOR_LEN = 64,
  parameter int CHAN_WIDTH = $clog2(VECTOR_LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync,
  input  logic signed [DIN_WIDTH-1:0] lamb1,
  input  logic signed [DIN_WIDTH-1:0] lamb2,
  input  logic signed [DIN_WIDTH-1:0] eigen1_y,
  input  logic signed [DIN_WIDTH-1:0] eigen2_y,
  input  logic signed [DIN_WIDTH-1:0] eigen_x,
  input  logic                        din_valid,
  input  logic                        din_error,
`ifdef DOA_ERR_FLAG_EN
  output logic [5*DIN_WIDTH:0]        m_data,
  output logic                        err_sticky,
`else
  output logic [5*DIN_WIDTH-1:0]      m_data,
`endif
  output logic [CHAN_WIDTH-1:0]       m_chan,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        frame_drop,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count
);

  localparam int PW = NUM_FIELDS * DIN_WIDTH;
`ifdef DOA_ERR_FLAG_EN
  localparam int MW = PW + 1;
`else
  localparam int MW = PW;
`endif
  localparam int AW = CHAN_WIDTH + 1;
  localparam logic [CHAN_WIDTH-1:0] LAST = CHAN_WIDTH'(VECTOR_LEN - 1);

  bank_st_t r_st [2];
  bank_st_t w_st_nxt [2];

  logic [CHAN_WIDTH-1:0] r_wr_cnt;
  logic r_wr_bank, r_filling, r_dropping, r_last_full;
  logic r_frame_drop;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  logic [CHAN_WIDTH-1:0] r_rd_ptr;
  logic r_rd_active, r_rd_bank;
  logic r_pend, r_pend_last, r_pend_bank;
  logic [CHAN_WIDTH-1:0] r_pend_chan;

  logic [1:0] r_sk_cnt;
  logic [MW-1:0] r_sk_data [2];
  logic [CHAN_WIDTH-1:0] r_sk_chan [2];
  logic r_sk_last [2];
  logic r_sk_bank [2];

  logic [PW-1:0] w_fields;
  logic [MW-1:0] w_wdata, w_rdata;
  logic w_abandon, w_start, w_empty0, w_empty1;
  logic w_claim, w_claim_bank, w_drop, w_wr_bank, w_we, w_full;
  logic [CHAN_WIDTH-1:0] w_wr_addr;
  logic w_full0, w_full1, w_sel, w_rd_avail, w_rd_bank;
  logic w_pop, w_issue, w_rd_last, w_release, w_push_idx;
  logic [1:0] w_occ;

  assign w_fields[FLD_LAMB1*DIN_WIDTH +: DIN_WIDTH]    = lamb1;
  assign w_fields[FLD_LAMB2*DIN_WIDTH +: DIN_WIDTH]    = lamb2;
  assign w_fields[FLD_EIGEN1_Y*DIN_WIDTH +: DIN_WIDTH] = eigen1_y;
  assign w_fields[FLD_EIGEN2_Y*DIN_WIDTH +: DIN_WIDTH] = eigen2_y;
  assign w_fields[FLD_EIGEN_X*DIN_WIDTH +: DIN_WIDTH]  = eigen_x;

`ifdef DOA_ERR_FLAG_EN
  assign w_wdata = {din_error, w_fields};
`else
  logic w_unused;
  assign w_unused = din_error;
  assign w_wdata  = w_fields;
`endif

  // Write side: sync abandons first, so a same-cycle sample is channel 0
  // and may reclaim the bank it just released.
  assign w_abandon    = sync && (r_wr_cnt != '0);
  assign w_start      = din_valid && (sync || (r_wr_cnt == '0));
  assign w_empty0     = (r_st[0] == BANK_EMPTY) ||
                        (w_abandon && r_filling && !r_wr_bank);
  assign w_empty1     = (r_st[1] == BANK_EMPTY) ||
                        (w_abandon && r_filling && r_wr_bank);
  assign w_claim      = w_start && (w_empty0 || w_empty1);
  assign w_claim_bank = !w_empty0;
  assign w_drop       = w_start && !(w_empty0 || w_empty1);
  assign w_wr_bank    = w_start ? w_claim_bank : r_wr_bank;
  assign w_wr_addr    = w_start ? '0 : r_wr_cnt;
  assign w_we         = w_claim || (din_valid && !w_start && r_filling);
  assign w_full       = w_we && (w_wr_addr == LAST);

  // Read side: oldest FULL bank first; reads issue only when the skid
  // is guaranteed room for the returning word.
  assign w_full0    = (r_st[0] == BANK_FULL);
  assign w_full1    = (r_st[1] == BANK_FULL);
  assign w_sel      = (w_full0 && w_full1) ? !r_last_full : w_full1;
  assign w_rd_avail = r_rd_active || w_full0 || w_full1;
  assign w_rd_bank  = r_rd_active ? r_rd_bank : w_sel;
  assign w_pop      = m_valid && m_ready;
  assign w_occ      = r_sk_cnt + {1'b0, r_pend} - {1'b0, w_pop};
  assign w_issue    = w_rd_avail && (w_occ <= 2'd1);
  assign w_rd_last  = (r_rd_ptr == LAST);
  assign w_release  = w_pop && m_last;
  assign w_push_idx = (r_sk_cnt == 2'd2) ||
                      ((r_sk_cnt == 2'd1) && !w_pop);

  doa_pingpong_ram #(
    .DW (MW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({w_wr_bank, w_wr_addr}),
    .i_wdata (w_wdata),
    .i_re    (w_issue),
    .i_raddr ({w_rd_bank, r_rd_ptr}),
    .o_rdata (w_rdata)
  );

  // Bank state next-state; later events take priority.
  always_comb begin
    w_st_nxt[0] = r_st[0];
    w_st_nxt[1] = r_st[1];
    if (w_abandon && r_filling) w_st_nxt[r_wr_bank] = BANK_EMPTY;
    if (w_claim) w_st_nxt[w_claim_bank] = BANK_FILLING;
    if (w_full) w_st_nxt[w_wr_bank] = BANK_FULL;
    if (w_issue && !r_rd_active) w_st_nxt[w_sel] = BANK_DRAINING;
    if (w_release) w_st_nxt[r_sk_bank[0]] = BANK_EMPTY;
  end

  // Bank state register and write-side bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st[0]      <= BANK_EMPTY;
      r_st[1]      <= BANK_EMPTY;
      r_wr_cnt     <= '0;
      r_wr_bank    <= 1'b0;
      r_filling    <= 1'b0;
      r_dropping   <= 1'b0;
      r_last_full  <= 1'b0;
      r_frame_drop <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_st[0]      <= w_st_nxt[0];
      r_st[1]      <= w_st_nxt[1];
      r_frame_drop <= w_drop;
      if (din_valid) r_wr_cnt <= w_wr_addr + CHAN_WIDTH'(1);
      else if (w_abandon) r_wr_cnt <= '0;
      if (w_claim) r_wr_bank <= w_claim_bank;
      if (w_claim) r_filling <= 1'b1;
      else if (w_full || w_abandon) r_filling <= 1'b0;
      if (w_start) r_dropping <= w_drop;
      else if (w_abandon || (din_valid && r_wr_cnt == LAST))
        r_dropping <= 1'b0;
      if (w_full) r_last_full <= w_wr_bank;
      if (w_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
    end
  end

  // Read pointer and in-flight RAM read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_rd_active <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_bank <= 1'b0;
      r_pend_chan <= '0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + CHAN_WIDTH'(1);
        r_rd_active <= !w_rd_last;
        r_rd_bank   <= w_rd_bank;
        r_pend_last <= w_rd_last;
        r_pend_bank <= w_rd_bank;
        r_pend_chan <= r_rd_ptr;
      end
    end
  end

  // Two-entry output skid; entry 0 drives the stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sk_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        r_sk_data[i] <= '0;
        r_sk_chan[i] <= '0;
        r_sk_last[i] <= 1'b0;
        r_sk_bank[i] <= 1'b0;
      end
    end else begin
      r_sk_cnt <= w_occ;
      if (w_pop) begin
        r_sk_data[0] <= r_sk_data[1];
        r_sk_chan[0] <= r_sk_chan[1];
        r_sk_last[0] <= r_sk_last[1];
        r_sk_bank[0] <= r_sk_bank[1];
      end
      if (r_pend) begin
        r_sk_data[w_push_idx] <= w_rdata;
        r_sk_chan[w_push_idx] <= r_pend_chan;
        r_sk_last[w_push_idx] <= r_pend_last;
        r_sk_bank[w_push_idx] <= r_pend_bank;
      end
    end
  end

`ifdef DOA_ERR_FLAG_EN
  logic r_err_sticky;

  // Per-frame error OR, cleared once the frame's last beat leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err_sticky <= 1'b0;
    else if (w_pop) begin
      if (m_last) r_err_sticky <= 1'b0;
      else if (m_data[MW-1]) r_err_sticky <= 1'b1;
    end
  end

  assign err_sticky = r_err_sticky;
`endif

  assign m_valid    = (r_sk_cnt != 2'd0);
  assign m_data     = r_sk_data[0];
  assign m_chan     = r_sk_chan[0];
  assign m_last     = r_sk_last[0] && m_valid;
  assign frame_drop = r_frame_drop;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_doa_frame_reader.sv
// tb_doa_frame_reader: scoreboard bench for doa_frame_reader.
// Table of frame scenarios plus latency and reset-mid-drain sequences.
module tb_doa_frame_reader;

  localparam int DW = 16;
  localparam int VL = 64;
  localparam int CW = 6;
  localparam int PW = 5 * DW;
`ifdef DOA_ERR_FLAG_EN
  localparam int MW = PW + 1;
`else
  localparam int MW = PW;
`endif

  typedef struct packed {
    logic          last;
    logic [CW-1:0] chan;
    logic [MW-1:0] data;
  } beat_t;

  typedef struct {
    int pre;
    bit sync_sep;
    bit sync_first;
    int frames;
    int nkeep;
    int rmode;
    bit err5;
    int exp_beats;
    int exp_drops;
    int exp_pulses;
  } row_t;

  logic clk = 1'b0;
  logic rst, sync, din_valid, din_error, m_ready;
  logic signed [DW-1:0] lamb1, lamb2, eigen1_y, eigen2_y, eigen_x;
  logic [MW-1:0] m_data;
  logic [CW-1:0] m_chan;
  logic m_valid, m_last, frame_drop;
  logic [15:0] drop_count;
`ifdef DOA_ERR_FLAG_EN
  logic err_sticky;
  logic exp_st = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int pulses = 0;
  int rdy_mode = 0;
  int exp_drop_total = 0;
  beat_t exp_q[$];
  row_t tbl[5];

  always #5 clk = ~clk;

  doa_frame_reader dut (
    .clk        (clk),
    .rst        (rst),
    .sync       (sync),
    .lamb1      (lamb1),
    .lamb2      (lamb2),
    .eigen1_y   (eigen1_y),
    .eigen2_y   (eigen2_y),
    .eigen_x    (eigen_x),
    .din_valid  (din_valid),
    .din_error  (din_error),
    .m_data     (m_data),
`ifdef DOA_ERR_FLAG_EN
    .err_sticky (err_sticky),
`endif
    .m_chan     (m_chan),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .frame_drop (frame_drop),
    .drop_count (drop_count)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pk(input int f, input int c);
    logic [DW-1:0] a, b, d, e, g;
    a = DW'(c);
    b = DW'(f);
    d = DW'(c * 3 + f);
    e = ~DW'(c);
    g = DW'(f * 256 + c);
    return {a, b, d, e, g};
  endfunction

  function automatic beat_t mk(input int f, input int c, input bit er);
    beat_t t;
    t.last = (c == VL - 1);
    t.chan = CW'(c);
`ifdef DOA_ERR_FLAG_EN
    t.data = {er, pk(f, c)};
`else
    t.data = pk(f, c);
    if (er) t.data = pk(f, c);
`endif
    return t;
  endfunction

  // Ready driver: 0 = always ready, 1 = held off, 2 = toggling.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) m_ready = 1'b1;
      else if (rdy_mode == 1) m_ready = 1'b0;
      else m_ready = ~m_ready;
    end
  end

  // Monitor: compare presented beat with scoreboard head every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_drop) pulses++;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat chan %0d", m_chan);
        end else begin
          chk(m_ready ? "beat" : "hold",
              128'({m_last, m_chan, m_data}), 128'(exp_q[0]));
          if (m_ready) begin
`ifdef DOA_ERR_FLAG_EN
            chk("err_sticky", 128'(err_sticky), 128'(exp_st));
            exp_st = exp_q[0].last ? 1'b0 :
                     (exp_st | exp_q[0].data[MW-1]);
`endif
            void'(exp_q.pop_front());
            beats++;
          end
        end
      end
    end
  end

  task automatic send(input int f, input int n, input bit keep,
                      input bit sfirst, input bit err5);
    for (int c = 0; c < n; c++) begin
      if (keep) exp_q.push_back(mk(f, c, err5 && c == 5));
      din_valid = 1'b1;
      sync      = sfirst && (c == 0);
      din_error = err5 && (c == 5);
      {lamb1, lamb2, eigen1_y, eigen2_y, eigen_x} = pk(f, c);
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    sync      = 1'b0;
    din_error = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 128'(n >= 3000), 128'(0));
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 3, 2, 1, 0, 128, 1, 1};
    tbl[1] = '{20, 1, 0, 1, 1, 0, 0, 64, 0, 0};
    tbl[2] = '{37, 0, 1, 1, 1, 0, 0, 64, 0, 0};
    tbl[3] = '{0, 0, 0, 2, 2, 2, 1, 128, 0, 0};
    tbl[4] = '{0, 0, 0, 2, 2, 0, 0, 128, 0, 0};

    rst = 1'b1;
    sync = 1'b0;
    din_valid = 1'b0;
    din_error = 1'b0;
    {lamb1, lamb2, eigen1_y, eigen2_y, eigen_x} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 128'({m_valid, m_last, m_chan, m_data, frame_drop,
                           drop_count}), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // One frame, idle output: valid 2 cycles after the last write.
    beats = 0;
    send(1, VL, 1, 0, 0);
    chk("lat_e0", 128'(m_valid), 128'(0));
    @(posedge clk);
    #1;
    chk("lat_e1", 128'(m_valid), 128'(0));
    @(posedge clk);
    #1;
    chk("lat_e2", 128'({m_valid, m_chan}), 128'({1'b1, 6'd0}));
    wait_drain("lat");
    chk("lat_beats", 128'(beats), 128'(VL));

    for (int r = 0; r < 5; r++) begin
      beats = 0;
      pulses = 0;
      rdy_mode = tbl[r].rmode;
      @(posedge clk);
      #1;
      if (tbl[r].pre > 0) send(100 + r, tbl[r].pre, 0, 0, 0);
      if (tbl[r].sync_sep) begin
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
      end
      for (int k = 0; k < tbl[r].frames; k++)
        send(10 * r + k, VL, k < tbl[r].nkeep,
             tbl[r].sync_first && k == 0, tbl[r].err5);
      rdy_mode = (tbl[r].rmode == 1) ? 0 : tbl[r].rmode;
      wait_drain($sformatf("row%0d", r));
      rdy_mode = 0;
      exp_drop_total += tbl[r].exp_drops;
      chk($sformatf("row%0d_beats", r), 128'(beats),
          128'(tbl[r].exp_beats));
      chk($sformatf("row%0d_drops", r), 128'(drop_count),
          128'(exp_drop_total));
      chk($sformatf("row%0d_pulses", r), 128'(pulses),
          128'(tbl[r].exp_pulses));
    end

    // Reset while channel 30 is presented, then a clean frame.
    begin
      int n;
      n = 0;
      rdy_mode = 0;
      @(posedge clk);
      #1;
      send(200, VL, 1, 0, 0);
      while (!(m_valid && m_chan == 6'd30) && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("ch30_timeout", 128'(n >= 500), 128'(0));
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid", 128'({m_valid, m_last, m_chan, m_data, frame_drop,
                           drop_count}), 128'(0));
      exp_q.delete();
`ifdef DOA_ERR_FLAG_EN
      exp_st = 1'b0;
`endif
      exp_drop_total = 0;
      @(posedge clk);
      #1;
      chk("rst_hold", 128'(m_valid), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      beats = 0;
      send(201, VL, 1, 0, 0);
      wait_drain("post_rst");
      chk("post_rst_beats", 128'(beats), 128'(VL));
      chk("post_rst_drops", 128'(drop_count), 128'(exp_drop_total));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/doa_frame_reader.md
DOA_FRAME_READER -- requirements
Module: doa_frame_reader

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16: width of each eigen field.
REQ-002 SHALL have parameter VECTOR_LEN, default 64: channels per frame, power of two, at least 4.
REQ-003 SHALL have parameter CHAN_WIDTH, default $clog2(VECTOR_LEN): width of the channel index.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port sync, input, 1: frame restart, driven by the correlator's new_acc.
REQ-007 SHALL have ports lamb1, lamb2, eigen1_y, eigen2_y, eigen_x, input, signed DIN_WIDTH each: eigen pipeline outputs.
REQ-008 SHALL have ports din_valid and din_error, input, 1 each: the eigen dout_valid and dout_error.
REQ-009 SHALL have port m_data, output, 5*DIN_WIDTH: fields packed MSB-first as {lamb1, lamb2, eigen1_y, eigen2_y, eigen_x}.
REQ-010 SHALL have port m_chan, output, CHAN_WIDTH: channel index of m_data.
REQ-011 SHALL have ports m_valid and m_last, output, 1 each; m_last marks channel VECTOR_LEN-1.
REQ-012 SHALL have port m_ready, input, 1: downstream accept.
REQ-013 SHALL have port frame_drop, output, 1: one-cycle pulse when an input frame is discarded.
REQ-014 SHALL have port drop_count, output, 16: saturating count of discarded frames.

Function
REQ-015 SHALL buffer two frames in a ping-pong memory: 2 banks x VECTOR_LEN x 5*DIN_WIDTH.
REQ-016 SHALL give each bank one of the states EMPTY, FILLING, FULL, DRAINING.
REQ-017 SHALL use a write counter that increments on each din_valid, writes at address wr_cnt, and wraps at VECTOR_LEN-1.
REQ-018 SHALL, when wr_cnt is 0 and din_valid is asserted, claim the lowest-indexed EMPTY bank (EMPTY->FILLING); the bank becomes FULL on the write at VECTOR_LEN-1.
REQ-019 SHALL, if no bank is EMPTY at frame start, discard all VECTOR_LEN samples of that frame, pulse frame_drop on its first sample, and increment drop_count, saturating at 0xFFFF.
REQ-020 SHALL, on sync with wr_cnt!=0, abandon the partial frame: wr_cnt returns to 0 and the FILLING bank returns to EMPTY, with no frame_drop pulse.
REQ-021 SHALL, on sync and din_valid in the same cycle, abandon first and then treat the sample as channel 0.
REQ-022 SHALL drain FULL banks in completion order (FULL->DRAINING), presenting channels 0..VECTOR_LEN-1 in order.
REQ-023 SHALL follow AXI-stream-style rules: a beat transfers on m_valid&&m_ready; m_data, m_chan and m_last hold stable while m_valid&&!m_ready.
REQ-024 SHALL use a one-cycle synchronous memory read with a 2-entry output skid, so that a bank drains at one beat per cycle under continuous m_ready.
REQ-025 SHALL assert m_valid for channel 0 exactly 2 cycles after the bank becomes FULL (write edge -> FULL, +1 read, +1 output register) when the output is idle.
REQ-026 SHALL return a bank to EMPTY in the cycle after its m_last beat transfers; that bank is claimable by a frame starting in that same cycle.
REQ-027 SHALL ignore din_error unless DOA_ERR_FLAG_EN is defined.

Reset
REQ-028 SHALL, while rst is high, force: all banks EMPTY, wr_cnt=0, read pointer 0, m_valid=0, m_last=0, m_data=0, m_chan=0, frame_drop=0, drop_count=0.
REQ-029 SHALL, on reset assertion mid-frame or mid-drain, discard all buffered data; memory contents are not cleared.
REQ-030 SHALL ignore the first din_valid after deassertion only if it coincides with the deassertion edge.

Configuration
REQ-031 SHALL, with DOA_ERR_FLAG_EN defined, store din_error as an extra memory bit, append it as the MSB of m_data (width 5*DIN_WIDTH+1), and OR it per frame into output err_sticky, which is held until m_last transfers.
REQ-032 SHALL, with DOA_ERR_FLAG_EN undefined, have no err_sticky port and leave m_data at 5*DIN_WIDTH.

Structure
REQ-033 SHALL place the bank-state enum, the field offsets of the packing order, and DROP_CNT_WIDTH=16 in package doa_pkg.
REQ-034 SHALL implement the ping-pong memory as sub-module doa_pingpong_ram (simple dual-port, 1-cycle read).

Verification
REQ-035 SHALL cover: one frame of 64 samples with lamb1=channel index, m_ready=1 -> 64 beats with m_chan 0..63, m_last on beat 63, first m_valid 2 cycles after the last write.
REQ-036 SHALL cover: three back-to-back frames with m_ready=0 -> frames 1 and 2 held, frame 3 dropped, frame_drop pulses once, drop_count=1.
REQ-037 SHALL cover: sync after 20 samples, then a full frame -> exactly 64 beats of the second frame only, drop_count=0.
REQ-038 SHALL cover: m_ready toggling 1/0 every cycle -> every channel delivered exactly once, in order, data stable while stalled.
REQ-039 SHALL cover: rst pulse during drain of channel 30 -> m_valid=0 next cycle, next full frame delivered from channel 0.
REQ-040 SHALL cover, with DOA_ERR_FLAG_EN: din_error=1 on channel 5 only -> MSB of m_data set on beat 5 only, err_sticky=1 until m_last.
